// File: rtl/alu_pkg.sv
// Shared definitions for the execute ALU stage.
//   cmd_e   : ARM data-processing opcode (instruction bits 24:21)
//   FLAG_*  : bit positions inside the NZCV register
//   state_e : stage sequencing (idle / multiply in progress)
package alu_pkg;

  typedef enum logic [3:0] {
    CMD_AND = 4'd0, CMD_EOR, CMD_SUB, CMD_RSB,
    CMD_ADD,        CMD_ADC, CMD_SBC, CMD_RSC,
    CMD_TST,        CMD_TEQ, CMD_CMP, CMD_CMN,
    CMD_ORR,        CMD_MOV, CMD_BIC, CMD_MVN
  } cmd_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  // Ops whose C/V come from the adder rather than the shifter.
  function automatic logic is_arith(cmd_e c);
    return c inside {CMD_SUB, CMD_RSB, CMD_ADD, CMD_ADC,
                     CMD_SBC, CMD_RSC, CMD_CMP, CMD_CMN};
  endfunction

  // Compare/test ops only touch flags.
  function automatic logic writes_rd(cmd_e c);
    return !(c inside {CMD_TST, CMD_TEQ, CMD_CMP, CMD_CMN});
  endfunction

endpackage

// File: rtl/exec_alu_stage_if.sv
// Request/response bus of the execute stage.
//   upstream  : in_valid/in_ready handshake + operation fields
//   downstream: out_valid/out_ready handshake + result, result_we
// master = producer of operations / consumer of results, slave = the stage.
interface exec_alu_stage_if #(parameter int WIDTH = 32) ();
  import alu_pkg::*;

  logic             in_valid;
  logic             in_ready;
  cmd_e             cmd;
  logic             s_bit;
  logic             is_rrx;
  logic             is_mul;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic             sh_c;
  logic             sh_c_valid;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             result_we;

  modport master (
    output in_valid, cmd, s_bit, is_rrx, is_mul, src1, src2, sh_c, sh_c_valid,
    output out_ready,
    input  in_ready, out_valid, result, result_we
  );

  modport slave (
    input  in_valid, cmd, s_bit, is_rrx, is_mul, src1, src2, sh_c, sh_c_valid,
    input  out_ready,
    output in_ready, out_valid, result, result_we
  );

endinterface

// File: rtl/mul_iter.sv
// Iterative radix-2 shift-add multiplier (low WIDTH bits of the product).
//   start        : latch operands, clear accumulator and counter
//   mcand_in     : multiplicand, shifted left each step
//   mplier_in    : multiplier, shifted right each step (LSB selects add)
//   done         : high during the last iteration cycle
//   product      : accumulator including the current step; valid with done
// Exposing the post-step value lets the caller capture the product on the
// same edge as the final iteration, so completion lands MUL_CYCLES edges
// after start.
module mul_iter #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] mcand_in,
  input  logic [WIDTH-1:0] mplier_in,
  output logic             done,
  output logic [WIDTH-1:0] product
);
  localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  logic             run;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc, mcand, mplier, acc_nxt;

  assign acc_nxt = acc + (mplier[0] ? mcand : '0);
  assign done    = run && (cnt == CW'(MUL_CYCLES - 1));
  assign product = acc_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      run    <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start && !run) begin
      run    <= 1'b1;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= mcand_in;
      mplier <= mplier_in;
    end else if (run) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= done ? '0 : cnt + 1'b1;
      if (done) run <= 1'b0;
    end
  end

endmodule

// File: rtl/exec_alu_stage.sv
// ARM execute stage: data-processing ALU, RRX, iterative MUL, NZCV register
// and a single registered output slot toward writeback.
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave side of exec_alu_stage_if (op in, result out)
//   flags      : architectural NZCV, N in bit 3
//   busy       : multiplier iterating (stage not accepting)
module exec_alu_stage
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  exec_alu_stage_if.slave      bus,
  output logic [3:0]           flags,
  output logic                 busy
);
  localparam int MSB = WIDTH - 1;

  state_e         state;
  logic           out_valid_q, we_q, mul_s;
  logic [MSB:0]   result_q;
  logic           accept, mul_done;
  logic [MSB:0]   mul_prod;
  cmd_e           cmd;
  logic           c_in;

  assign cmd  = bus.cmd;
  assign c_in = flags[FLAG_C];
  assign busy = (state == ST_MUL);

  // A full slot may be refilled on the same edge it drains: no bubble.
  assign bus.in_ready  = (state == ST_IDLE) && (!out_valid_q || bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.result_we = we_q;

  // ---------------- adder operand steering ----------------
  // Subtracts are a + ~b + cin so C comes out as ARM not-borrow.
  logic [MSB:0] op_a, op_b;
  logic         cin;
  logic [WIDTH:0] sum;
  logic         add_v;

  always_comb begin
    op_a = bus.src1;
    op_b = bus.src2;
    cin  = 1'b0;
    case (cmd)
      CMD_SUB, CMD_CMP: begin op_b = ~bus.src2; cin = 1'b1; end
      CMD_SBC:          begin op_b = ~bus.src2; cin = c_in; end
      CMD_RSB:          begin op_a = bus.src2; op_b = ~bus.src1; cin = 1'b1; end
      CMD_RSC:          begin op_a = bus.src2; op_b = ~bus.src1; cin = c_in; end
      CMD_ADC:          cin = c_in;
      default: ;
    endcase
  end

  assign sum   = {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, cin};
  // Overflow: both effective operands share a sign the result lacks.
  assign add_v = (op_a[MSB] == op_b[MSB]) && (sum[MSB] != op_a[MSB]);

  // ---------------- result select ----------------
  logic [MSB:0] alu_res;

  always_comb begin
    case (cmd)
      CMD_AND, CMD_TST: alu_res = bus.src1 & bus.src2;
      CMD_EOR, CMD_TEQ: alu_res = bus.src1 ^ bus.src2;
      CMD_ORR:          alu_res = bus.src1 | bus.src2;
      CMD_MOV:          alu_res = bus.src2;
      CMD_BIC:          alu_res = bus.src1 & ~bus.src2;
      CMD_MVN:          alu_res = ~bus.src2;
      default:          alu_res = sum[MSB:0];
    endcase
    if (bus.is_rrx) alu_res = {c_in, bus.src2[MSB:1]};
  end

  // ---------------- next flags ----------------
  logic [3:0] flags_alu, flags_mul;

  always_comb begin
    flags_alu = flags;
    if (bus.s_bit) begin
      flags_alu[FLAG_N] = alu_res[MSB];
      flags_alu[FLAG_Z] = (alu_res == '0);
      if (bus.is_rrx) begin
        flags_alu[FLAG_C] = bus.src2[0];
      end else if (is_arith(cmd)) begin
        flags_alu[FLAG_C] = sum[WIDTH];
        flags_alu[FLAG_V] = add_v;
      end else if (bus.sh_c_valid) begin
        flags_alu[FLAG_C] = bus.sh_c;
      end
    end
  end

  // MUL only ever touches N and Z.
  always_comb begin
    flags_mul = flags;
    if (mul_s) begin
      flags_mul[FLAG_N] = mul_prod[MSB];
      flags_mul[FLAG_Z] = (mul_prod == '0);
    end
  end

  // ---------------- multiplier ----------------
  mul_iter #(.WIDTH(WIDTH), .MUL_CYCLES(MUL_CYCLES)) u_mul (
    .clk       (clk),
    .reset     (reset),
    .start     (accept && bus.is_mul),
    .mcand_in  (bus.src1),
    .mplier_in (bus.src2),
    .done      (mul_done),
    .product   (mul_prod)
  );

  // ---------------- state, flags, output slot ----------------
  // accept only happens in IDLE and mul_done only in MUL, so the two
  // load paths below never collide.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      we_q        <= 1'b0;
      flags       <= '0;
      mul_s       <= 1'b0;
    end else begin
      if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;

      if (accept && !bus.is_mul) begin
        result_q    <= alu_res;
        we_q        <= writes_rd(cmd);
        flags       <= flags_alu;
        out_valid_q <= 1'b1;
      end

      if (accept && bus.is_mul) begin
        state <= ST_MUL;
        mul_s <= bus.s_bit;
      end

      if (state == ST_MUL && mul_done) begin
        state       <= ST_IDLE;
        result_q    <= mul_prod;
        we_q        <= 1'b1;
        flags       <= flags_mul;
        out_valid_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_exec_alu_stage.sv
module tb_exec_alu_stage;
  import alu_pkg::*;

  localparam int MUL_CYCLES = 32;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] flags;
  logic       busy;

  int tests = 0;
  int fails = 0;

  exec_alu_stage_if #(.WIDTH(32)) ifc ();

  exec_alu_stage #(.WIDTH(32), .MUL_CYCLES(MUL_CYCLES)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave),
    .flags (flags),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: ARM data-processing rules with plain integer arithmetic.
  function automatic void model(input cmd_e c, input logic s, rrx, mul,
                                input logic [31:0] a, b, input logic shc, shcv,
                                input logic [3:0] fi,
                                output logic [31:0] r, output logic we,
                                output logic [3:0] fo);
    longint u, sg, bor;
    logic [31:0] x, y;
    logic [63:0] p;
    logic cf, vf;
    bit arith;
    fo = fi;
    we = !(c inside {CMD_TST, CMD_TEQ, CMD_CMP, CMD_CMN});
    r  = '0;
    cf = fi[1];
    vf = fi[0];
    arith = 0;
    if (mul) begin
      p  = {32'b0, a} * {32'b0, b};
      r  = p[31:0];
      we = 1'b1;
    end else if (rrx) begin
      r  = {fi[1], b[31:1]};
      cf = b[0];
    end else if (c inside {CMD_ADD, CMD_ADC, CMD_CMN}) begin
      arith = 1;
      bor = (c == CMD_ADC) ? longint'(fi[1]) : 0;
      u   = longint'(a) + longint'(b) + bor;
      sg  = longint'($signed(a)) + longint'($signed(b)) + bor;
      r   = u[31:0];
      cf  = (u > 64'hFFFF_FFFF);
      vf  = (sg > longint'(32'sh7FFF_FFFF)) || (sg < longint'(32'sh8000_0000));
    end else if (c inside {CMD_SUB, CMD_SBC, CMD_CMP, CMD_RSB, CMD_RSC}) begin
      arith = 1;
      x = (c inside {CMD_RSB, CMD_RSC}) ? b : a;
      y = (c inside {CMD_RSB, CMD_RSC}) ? a : b;
      bor = (c inside {CMD_SBC, CMD_RSC}) ? longint'(!fi[1]) : 0;
      u   = longint'(x) - longint'(y) - bor;
      sg  = longint'($signed(x)) - longint'($signed(y)) - bor;
      r   = u[31:0];
      cf  = (u >= 0);
      vf  = (sg > longint'(32'sh7FFF_FFFF)) || (sg < longint'(32'sh8000_0000));
    end else begin
      case (c)
        CMD_AND, CMD_TST: r = a & b;
        CMD_EOR, CMD_TEQ: r = a ^ b;
        CMD_ORR:          r = a | b;
        CMD_MOV:          r = b;
        CMD_BIC:          r = a & ~b;
        default:          r = ~b;
      endcase
      if (shcv) cf = shc;
    end
    if (s) begin
      fo[3] = r[31];
      fo[2] = (r == 32'd0);
      if (!mul) fo[1] = cf;
      if (arith) fo[0] = vf;
    end
  endfunction

  task automatic set_op(input cmd_e c, input logic s, rrx, mul,
                        input logic [31:0] a, b, input logic shc, shcv);
    ifc.in_valid   = 1'b1;
    ifc.cmd        = c;
    ifc.s_bit      = s;
    ifc.is_rrx     = rrx;
    ifc.is_mul     = mul;
    ifc.src1       = a;
    ifc.src2       = b;
    ifc.sh_c       = shc;
    ifc.sh_c_valid = shcv;
  endtask

  // Waits for a multiply started on the last edge; returns edges taken.
  task automatic wait_out(output int cyc, output int bad_busy);
    cyc = 0;
    bad_busy = 0;
    while (!ifc.out_valid && cyc < MUL_CYCLES + 8) begin
      if (busy !== 1'b1 || ifc.in_ready !== 1'b0) bad_busy++;
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  typedef struct {
    cmd_e        cmd;
    logic        s, rrx, shc, shcv;
    logic [31:0] a, b, r;
    logic        we;
    logic [3:0]  f;
  } vec_t;

  vec_t       tv[20];
  logic [3:0] mf;
  logic [31:0] er;
  logic       ewe;
  logic [3:0] ef;

  initial begin
    int cyc, bad;
    ifc.in_valid = 0; ifc.cmd = CMD_AND; ifc.s_bit = 0; ifc.is_rrx = 0;
    ifc.is_mul = 0; ifc.src1 = 0; ifc.src2 = 0; ifc.sh_c = 0;
    ifc.sh_c_valid = 0; ifc.out_ready = 1;

    //            cmd      s rrx shc shcv a             b             r             we f
    tv[0]  = '{CMD_ADD, 1, 0, 0, 0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1, 4'b1001};
    tv[1]  = '{CMD_CMP, 1, 0, 0, 0, 32'd5,        32'd5,        32'h00000000, 0, 4'b0110};
    tv[2]  = '{CMD_SBC, 1, 0, 0, 0, 32'd10,       32'd3,        32'd7,        1, 4'b0010};
    tv[3]  = '{CMD_ADD, 1, 0, 0, 0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1, 4'b1001};
    tv[4]  = '{CMD_MOV, 1, 0, 1, 1, 32'h0,        32'h0,        32'h00000000, 1, 4'b0111};
    tv[5]  = '{CMD_MOV, 1, 0, 0, 0, 32'h0,        32'h0,        32'h00000000, 1, 4'b0111};
    tv[6]  = '{CMD_MOV, 1, 1, 0, 0, 32'h0,        32'h00000003, 32'h80000001, 1, 4'b1011};
    tv[7]  = '{CMD_ADC, 1, 0, 0, 0, 32'd1,        32'd2,        32'd4,        1, 4'b0000};
    tv[8]  = '{CMD_ADD, 0, 0, 0, 0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, 4'b0000};
    tv[9]  = '{CMD_RSB, 1, 0, 0, 0, 32'd3,        32'd10,       32'd7,        1, 4'b0010};
    tv[10] = '{CMD_TEQ, 1, 0, 0, 0, 32'hF0,       32'hF0,       32'h00000000, 0, 4'b0110};
    tv[11] = '{CMD_BIC, 1, 0, 0, 0, 32'hFF,       32'h0F,       32'hF0,       1, 4'b0010};
    tv[12] = '{CMD_MVN, 1, 0, 0, 1, 32'h0,        32'h0,        32'hFFFFFFFF, 1, 4'b1000};
    tv[13] = '{CMD_SBC, 1, 0, 0, 0, 32'd10,       32'd3,        32'd6,        1, 4'b0010};
    tv[14] = '{CMD_RSC, 1, 0, 0, 0, 32'd5,        32'd3,        32'hFFFFFFFE, 1, 4'b1000};
    tv[15] = '{CMD_SUB, 1, 0, 0, 0, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1, 4'b0011};
    tv[16] = '{CMD_AND, 1, 0, 1, 1, 32'hF0F0,     32'h0FF0,     32'h000000F0, 1, 4'b0011};
    tv[17] = '{CMD_ORR, 0, 0, 0, 0, 32'd1,        32'd2,        32'd3,        1, 4'b0011};
    tv[18] = '{CMD_TST, 1, 0, 0, 0, 32'd1,        32'd2,        32'h00000000, 0, 4'b0111};
    tv[19] = '{CMD_CMN, 1, 0, 0, 0, 32'd1,        32'hFFFFFFFF, 32'h00000000, 0, 4'b0110};

    // ---- reset state ----
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 0;
    #1;
    chk("rst_out_valid", 32'(ifc.out_valid), 32'd0);
    chk("rst_result",    ifc.result,         32'd0);
    chk("rst_we",        32'(ifc.result_we), 32'd0);
    chk("rst_flags",     32'(flags),         32'd0);
    chk("rst_busy",      32'(busy),          32'd0);
    chk("rst_in_ready",  32'(ifc.in_ready),  32'd1);

    // ---- directed table, back-to-back accepts ----
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      set_op(tv[i].cmd, tv[i].s, tv[i].rrx, 1'b0, tv[i].a, tv[i].b, tv[i].shc, tv[i].shcv);
      @(posedge clk); #1;
      ifc.in_valid = 0;
      chk($sformatf("tv%0d_valid", i),  32'(ifc.out_valid), 32'd1);
      chk($sformatf("tv%0d_result", i), ifc.result,         tv[i].r);
      chk($sformatf("tv%0d_we", i),     32'(ifc.result_we), 32'(tv[i].we));
      chk($sformatf("tv%0d_flags", i),  32'(flags),         32'(tv[i].f));
    end
    mf = tv[19].f;

    // ---- MUL latency and busy ----
    @(negedge clk);
    set_op(CMD_AND, 1, 0, 1, 32'h00010001, 32'h0000FFFF, 0, 0);
    model(CMD_AND, 1, 0, 1, 32'h00010001, 32'h0000FFFF, 0, 0, mf, er, ewe, ef);
    @(posedge clk); #1;
    ifc.in_valid = 0;
    wait_out(cyc, bad);
    chk("mul_cycles",    32'(cyc),           32'(MUL_CYCLES));
    chk("mul_busy_hold", 32'(bad),           32'd0);
    chk("mul_result",    ifc.result,         32'hFFFFFFFF);
    chk("mul_flags",     32'(flags),         32'(ef));
    chk("mul_busy_done", 32'(busy),          32'd0);
    mf = ef;

    @(posedge clk); #1;
    chk("drain_out_valid", 32'(ifc.out_valid), 32'd0);

    // ---- output stall then same-cycle reload ----
    @(negedge clk);
    ifc.out_ready = 0;
    set_op(CMD_ADD, 0, 0, 0, 32'd5, 32'd6, 0, 0);
    @(posedge clk); #1;
    chk("stall_load", ifc.result, 32'd11);
    @(negedge clk);
    set_op(CMD_SUB, 1, 0, 0, 32'd20, 32'd3, 0, 0);
    model(CMD_SUB, 1, 0, 0, 32'd20, 32'd3, 0, 0, mf, er, ewe, ef);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("stall_in_ready", 32'(ifc.in_ready),  32'd0);
      chk("stall_result",   ifc.result,         32'd11);
      chk("stall_valid",    32'(ifc.out_valid), 32'd1);
      chk("stall_flags",    32'(flags),         32'(mf));
    end
    @(negedge clk);
    ifc.out_ready = 1;
    #1;
    chk("release_in_ready", 32'(ifc.in_ready), 32'd1);
    @(posedge clk); #1;
    ifc.in_valid = 0;
    chk("reload_result", ifc.result,         er);
    chk("reload_valid",  32'(ifc.out_valid), 32'd1);
    chk("reload_flags",  32'(flags),         32'(ef));
    mf = ef;

    // ---- reset during multiply ----
    @(negedge clk);
    set_op(CMD_MOV, 1, 0, 1, 32'h12345678, 32'h9ABCDEF1, 0, 0);
    @(posedge clk); #1;
    ifc.in_valid = 0;
    repeat (10) @(posedge clk);
    @(negedge clk) reset = 1;
    @(posedge clk); #1;
    chk("mrst_out_valid", 32'(ifc.out_valid), 32'd0);
    chk("mrst_result",    ifc.result,         32'd0);
    chk("mrst_we",        32'(ifc.result_we), 32'd0);
    chk("mrst_flags",     32'(flags),         32'd0);
    chk("mrst_busy",      32'(busy),          32'd0);
    chk("mrst_in_ready",  32'(ifc.in_ready),  32'd1);
    @(negedge clk) reset = 0;
    repeat (MUL_CYCLES + 4) @(posedge clk);
    #1;
    chk("mrst_no_late_result", 32'(ifc.out_valid), 32'd0);
    mf = 4'b0000;

    // ---- randomized ops against the model ----
    for (int i = 0; i < 300; i++) begin
      cmd_e c;
      logic s, rrx, mul, shc, shcv;
      logic [31:0] a, b;
      logic [31:0] pick [5];
      pick[0] = 32'h0; pick[1] = 32'h1; pick[2] = 32'h7FFFFFFF;
      pick[3] = 32'h80000000; pick[4] = 32'hFFFFFFFF;
      c    = cmd_e'($urandom_range(0, 15));
      s    = 1'($urandom_range(0, 1));
      mul  = ($urandom_range(0, 19) == 0);
      rrx  = ($urandom_range(0, 9) == 0);
      if (rrx && !mul) c = CMD_MOV;
      shc  = 1'($urandom_range(0, 1));
      shcv = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 4)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 4)] : $urandom;
      model(c, s, rrx, mul, a, b, shc, shcv, mf, er, ewe, ef);
      @(negedge clk);
      set_op(c, s, rrx, mul, a, b, shc, shcv);
      @(posedge clk); #1;
      ifc.in_valid = 0;
      if (mul) begin
        wait_out(cyc, bad);
        chk($sformatf("rnd%0d_mul_cycles", i), 32'(cyc), 32'(MUL_CYCLES));
      end
      chk($sformatf("rnd%0d_valid", i),  32'(ifc.out_valid), 32'd1);
      chk($sformatf("rnd%0d_result", i), ifc.result,         er);
      chk($sformatf("rnd%0d_we", i),     32'(ifc.result_we), 32'(ewe));
      chk($sformatf("rnd%0d_flags", i),  32'(flags),         32'(ef));
      mf = ef;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
